// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned AMT_W  = 4;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the datapath control FSM and the shift sequencer.
interface shift_sequencer_if;
  import shift_pkg::*;

  logic              start;
  logic [DATA_W-1:0] in;
  logic [1:0]        shift;
  logic [AMT_W-1:0]  amt;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] sout;

  // Requester side.
  modport master (
    output start, in, shift, amt,
    input  busy, done, sout
  );

  // Sequencer side.
  modport slave (
    input  start, in, shift, amt,
    output busy, done, sout
  );

endinterface

// File: rtl/shifter.sv
// Single-step 16-bit shifter: none, shift left, logical right or arithmetic right by one.
module shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  shift_op_t         shift,
  output logic [DATA_W-1:0] out
);

  // Select one of the four one-position shift results.
  always_comb begin
    out = in;
    case (shift)
      SH_NONE: out = in;
      SH_LSL:  out = {in[DATA_W-2:0], 1'b0};
      SH_LSR:  out = {1'b0, in[DATA_W-1:1]};
      SH_ASR:  out = {in[DATA_W-1], in[DATA_W-1:1]};
      default: out = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterates the single-step shifter once per clock to realise 0-15 position shifts.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] sout_q, sout_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  shift_op_t         op_q, op_d;
  logic [DATA_W-1:0] step;
  logic              accept;

  shifter u_shifter (
    .in    (sout_q),
    .shift (op_q),
    .out   (step)
  );

  // A new request is taken only when not iterating; start during SHIFT is dropped.
  assign accept = ((state_q == IDLE) || (state_q == DONE)) && bus.start;

  // Next-state, capture and iteration logic.
  always_comb begin
    state_d = state_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          sout_d = bus.in;
          cnt_d  = bus.amt;
          op_d   = shift_op_t'(bus.shift);
          // Zero distance or no-op finishes without iterating.
          if ((bus.amt == '0) || (shift_op_t'(bus.shift) == SH_NONE)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sout_d = step;
        cnt_d  = cnt_q - AMT_W'(1);
        // Exit on the last step so cnt never wraps.
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sout_q  <= '0;
      cnt_q   <= '0;
      op_q    <= SH_NONE;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Status outputs are pure decodes of the registered state.
  always_comb begin
    bus.busy = (state_q == SHIFT);
    bus.done = (state_q == DONE);
    bus.sout = sout_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a request at the current negedge and follow it to its done pulse.
  // poke_at >= 0 pulses start with junk inputs at that sample index while busy.
  task automatic run_op(input string tag, input logic [15:0] din, input logic [1:0] sh,
                        input logic [3:0] a, input logic [15:0] exp, input int poke_at);
    int lat_exp;
    int busy_n;
    int lat;
    bit seen;
    lat_exp = ((a == 4'd0) || (sh == 2'b00)) ? 0 : int'(a);
    busy_n  = 0;
    lat     = -1;
    seen    = 1'b0;
    bus.start = 1'b1;
    bus.in    = din;
    bus.shift = sh;
    bus.amt   = a;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in    = ~din;
    bus.shift = ~sh;
    bus.amt   = ~a;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      if (k == poke_at) begin
        bus.start = 1'b1;
        bus.in    = 16'h1234;
        bus.shift = 2'b01;
        bus.amt   = 4'd2;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check_eq({tag, "_busy"}, 32'(busy_n), 32'(lat_exp));
    check_eq({tag, "_sout"}, 32'(bus.sout), 32'(exp));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int dones;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in    = 16'h0;
    bus.shift = 2'b00;
    bus.amt   = 4'd0;
    #12;
    check_eq("rst_sout", 32'(bus.sout), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // First request right after reset release.
    run_op("lsl1", 16'hF0CF, 2'b01, 4'd1, 16'hE19E, -1);
    idle_cycles(2);
    check_eq("idle_busy", 32'(bus.busy), 32'h0);
    check_eq("idle_done", 32'(bus.done), 32'h0);
    check_eq("idle_hold", 32'(bus.sout), 32'hE19E);
    run_op("lsr4", 16'hF0CF, 2'b10, 4'd4, 16'h0F0C, -1);
    idle_cycles(1);
    run_op("asr4", 16'hF0CF, 2'b11, 4'd4, 16'hFF0C, -1);
    idle_cycles(1);
    run_op("lsl15", 16'hF0CF, 2'b01, 4'd15, 16'h8000, -1);
    idle_cycles(1);
    run_op("none7", 16'h1234, 2'b00, 4'd7, 16'h1234, -1);
    idle_cycles(1);
    run_op("amt0", 16'hA5A5, 2'b10, 4'd0, 16'hA5A5, -1);
    idle_cycles(1);

    // start pulsed mid-SHIFT must be ignored, then the block falls idle.
    run_op("poke", 16'hF0CF, 2'b10, 4'd4, 16'h0F0C, 1);
    @(negedge clk);
    check_eq("poke_idle_busy", 32'(bus.busy), 32'h0);
    check_eq("poke_idle_done", 32'(bus.done), 32'h0);
    idle_cycles(1);

    // Back-to-back: second request issued during the DONE cycle.
    run_op("b2b_a", 16'h8001, 2'b11, 4'd2, 16'hE000, -1);
    run_op("b2b_b", 16'h00FF, 2'b01, 4'd3, 16'h07F8, -1);
    run_op("b2b_c", 16'h4321, 2'b00, 4'd9, 16'h4321, -1);
    run_op("b2b_d", 16'h8000, 2'b11, 4'd15, 16'hFFFF, -1);
    idle_cycles(2);

    // Reset mid-SHIFT aborts immediately and suppresses done.
    bus.start = 1'b1;
    bus.in    = 16'hFFFF;
    bus.shift = 2'b01;
    bus.amt   = 4'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    idle_cycles(3);
    check_eq("pre_rst_busy", 32'(bus.busy), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_sout", 32'(bus.sout), 32'h0);
    check_eq("arst_busy", 32'(bus.busy), 32'h0);
    check_eq("arst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check_eq("post_rst_quiet", 32'(dones), 32'h0);
    run_op("post_rst", 16'h0003, 2'b01, 4'd2, 16'h000C, -1);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
